// File: rtl/pipelined_control_unit.sv
// ID/EX control register: decodes opcode/funct into datapath controls and holds them
// with a valid bit, plus stall/flush handling, a sticky halt and return-stack depth tracking.
module pipelined_control_unit #(
  parameter int OP_W        = 6,
  parameter int FUNCT_W     = 6,
  parameter int ALUOP_W     = 4,
  parameter int STACK_DEPTH = 8,
  parameter int SP_W        = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               instr_valid,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               stall,
  input  logic               flush,
  output logic [1:0]         RegDst,
  output logic               ALUSrc,
  output logic [1:0]         MemtoReg,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               RegWrite,
  output logic               Branch,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         Jump,
  output logic               ctrl_valid,
  output logic               halt,
  output logic [1:0]         fault,
  output logic [SP_W-1:0]    stack_ptr
);

  localparam int CTRL_W = 11 + ALUOP_W;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
  localparam logic [OP_W-1:0] OP_BR4   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BR5   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_BR6   = OP_W'(6'b000110);
  localparam logic [OP_W-1:0] OP_BR7   = OP_W'(6'b000111);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_BR8   = OP_W'(6'b001001);
  localparam logic [OP_W-1:0] OP_BR9   = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(6'b101101);

  localparam logic [FUNCT_W-1:0] FN_JS = FUNCT_W'(6'b001000);

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_OVF   = 2'b01;
  localparam logic [1:0] FAULT_UNF   = 2'b10;
  localparam logic [1:0] FAULT_ILLEG = 2'b11;

  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [1:0]         d_reg_dst;
  logic               d_alu_src;
  logic [1:0]         d_mem_to_reg;
  logic               d_mem_write;
  logic               d_mem_read;
  logic               d_reg_write;
  logic               d_branch;
  logic [ALUOP_W-1:0] d_alu_op;
  logic [1:0]         d_jump;
  logic               d_legal;
  logic               d_halt_op;
  logic               d_push;
  logic               d_pop;

  always_comb begin
    d_reg_dst    = 2'b00;
    d_alu_src    = 1'b0;
    d_mem_to_reg = 2'b00;
    d_mem_write  = 1'b0;
    d_mem_read   = 1'b0;
    d_reg_write  = 1'b0;
    d_branch     = 1'b0;
    d_alu_op     = '0;
    d_jump       = 2'b00;
    d_legal      = 1'b1;
    d_halt_op    = 1'b0;
    d_push       = 1'b0;
    d_pop        = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JS) begin
          d_reg_write  = 1'b1;
          d_mem_read   = 1'b1;
          d_mem_to_reg = 2'b11;
          d_jump       = 2'b10;
          d_pop        = 1'b1;
        end else begin
          d_reg_dst   = 2'b01;
          d_reg_write = 1'b1;
          d_alu_op    = ALUOP_W'(4'h2);
        end
      end
      OP_LW: begin
        d_alu_src    = 1'b1;
        d_reg_write  = 1'b1;
        d_mem_read   = 1'b1;
        d_mem_to_reg = 2'b01;
      end
      OP_SW: begin
        d_alu_src   = 1'b1;
        d_mem_write = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
        d_alu_op    = (opcode == OP_ADDI) ? ALUOP_W'(4'h0) :
                      (opcode == OP_ANDI) ? ALUOP_W'(4'h1) : ALUOP_W'(4'h3);
      end
      OP_J: d_jump = 2'b01;
      OP_JAL: begin
        d_reg_write  = 1'b1;
        d_mem_write  = 1'b1;
        d_mem_to_reg = 2'b10;
        d_reg_dst    = 2'b10;
        d_jump       = 2'b01;
        d_push       = 1'b1;
      end
      // 0001xx branches map straight onto ALUOp 4..7
      OP_BR4, OP_BR5, OP_BR6, OP_BR7: begin
        d_branch = 1'b1;
        d_alu_op = ALUOP_W'({2'b01, opcode[1:0]});
      end
      OP_BR8: begin
        d_branch = 1'b1;
        d_alu_op = ALUOP_W'(4'h8);
      end
      OP_BR9: begin
        d_branch = 1'b1;
        d_alu_op = ALUOP_W'(4'h9);
      end
      OP_HALT: d_halt_op = 1'b1;
      default: d_legal = 1'b0;
    endcase
  end

  logic [CTRL_W-1:0] dec_ctrl;
  logic [CTRL_W-1:0] ctrl_q;
  logic              ovf;
  logic              unf;
  logic              trap;
  logic              take;
  logic [1:0]        trap_code;

  assign dec_ctrl = {d_reg_dst, d_alu_src, d_mem_to_reg, d_mem_write, d_mem_read,
                     d_reg_write, d_branch, d_alu_op, d_jump};

  assign ovf  = d_push && (stack_ptr == SP_FULL);
  assign unf  = d_pop && (stack_ptr == '0);
  assign trap = instr_valid && (!d_legal || d_halt_op || ovf || unf);
  assign take = instr_valid && !trap;

  always_comb begin
    trap_code = FAULT_NONE;
    if (!d_legal)  trap_code = FAULT_ILLEG;
    else if (ovf)  trap_code = FAULT_OVF;
    else if (unf)  trap_code = FAULT_UNF;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ctrl_q     <= '0;
      ctrl_valid <= 1'b0;
      halt       <= 1'b0;
      fault      <= FAULT_NONE;
      stack_ptr  <= '0;
    end else if (halt || flush) begin
      ctrl_q     <= '0;
      ctrl_valid <= 1'b0;
    end else if (!stall) begin
      ctrl_q     <= take ? dec_ctrl : '0;
      ctrl_valid <= take;
      // halt already blocks this branch, so only the first fault is ever recorded
      if (trap) begin
        halt  <= 1'b1;
        fault <= trap_code;
      end
      if (take && d_push)     stack_ptr <= stack_ptr + 1'b1;
      else if (take && d_pop) stack_ptr <= stack_ptr - 1'b1;
    end
  end

  assign {RegDst, ALUSrc, MemtoReg, MemWrite, MemRead, RegWrite, Branch, ALUOp, Jump} = ctrl_q;

endmodule
